// File: rtl/riscv_cpu_pkg.sv
// Shared CPU types: access-size encoding and the default datapath width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package riscv_cpu_pkg;

  localparam int DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    LSU_BYTE = 2'b00,
    LSU_HALF = 2'b01,
    LSU_WORD = 2'b10
  } lsu_type_e;

endpackage

// File: rtl/lsu_meta_fifo.sv
// Small FIFO holding per-transaction metadata between grant and response.
// Latency: head is readable combinationally; a push is visible the next cycle.
// Backpressure: pushes while full and pops while empty are ignored; callers gate on full/empty.
module lsu_meta_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

  assign full_o  = (count == CNT_W'(DEPTH));
  assign empty_o = (count == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign rdata_o = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; simultaneous push/pop keeps the count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are don't-care until written so no reset.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata_i;
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: address generation, byte-lane steering, in-order response formatting.
// Latency: request side is combinational to data_req_o; load result is combinational on data_rvalid_i.
// Backpressure: requests stall while MAX_OUTSTANDING transactions await responses; misaligned ones are dropped at once.
module load_store_unit #(
  parameter int DATA_WIDTH      = riscv_cpu_pkg::DATA_WIDTH,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    req_i,
  input  logic                    we_i,
  input  logic [1:0]              type_i,
  input  logic                    sign_ext_i,
  input  logic [DATA_WIDTH-1:0]   operand_a_i,
  input  logic [DATA_WIDTH-1:0]   operand_b_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  output logic                    ready_o,
  output logic                    misaligned_o,
  output logic                    rvalid_o,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic                    busy_o,
  output logic                    data_req_o,
  input  logic                    data_gnt_i,
  input  logic                    data_rvalid_i,
  output logic [DATA_WIDTH-1:0]   data_addr_o,
  output logic                    data_we_o,
  output logic [DATA_WIDTH/8-1:0] data_be_o,
  output logic [DATA_WIDTH-1:0]   data_wdata_o,
  input  logic [DATA_WIDTH-1:0]   data_rdata_i
);

  import riscv_cpu_pkg::*;

  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int OFF_W  = $clog2(NBYTES);

  typedef struct packed {
    logic             we;
    lsu_type_e        typ;
    logic             sign_ext;
    logic [OFF_W-1:0] offset;
  } meta_t;

  localparam int META_W = $bits(meta_t);

  logic [DATA_WIDTH-1:0] eff_addr;
  logic [OFF_W-1:0]      offset;
  lsu_type_e             req_type;
  logic                  misaligned;
  logic [NBYTES-1:0]     be;
  logic                  grant;
  logic                  pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  meta_t                 meta_in;
  meta_t                 head;
  logic [META_W-1:0]     fifo_rdata;
  logic [DATA_WIDTH-1:0] shifted;

  assign eff_addr = operand_a_i + operand_b_i;
  assign offset   = eff_addr[OFF_W-1:0];
  assign req_type = lsu_type_e'(type_i);

  // Alignment check and byte-enable generation from access size and lane offset.
  always_comb begin
    misaligned = 1'b0;
    be         = '0;
    case (req_type)
      LSU_BYTE: begin
        be = NBYTES'(1) << offset;
      end
      LSU_HALF: begin
        misaligned = offset[0];
        be         = NBYTES'(3) << offset;
      end
      default: begin
        misaligned = |offset;
        be         = '1;
      end
    endcase
  end

  // Reset gates the handshake so nothing is issued or consumed while held in reset.
  assign data_req_o   = rst_ni & req_i & ~misaligned & ~fifo_full;
  assign misaligned_o = rst_ni & req_i & misaligned;
  assign grant        = data_req_o & data_gnt_i;
  assign ready_o      = grant | misaligned_o;

  assign data_addr_o  = {eff_addr[DATA_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
  assign data_we_o    = we_i;
  assign data_be_o    = be;
  assign data_wdata_o = wdata_i << {offset, 3'b000};

  // A response with nothing outstanding is stray and must not disturb the queue.
  assign pop     = data_rvalid_i & ~fifo_empty;
  assign busy_o  = ~fifo_empty;

  assign meta_in = '{we: we_i, typ: req_type, sign_ext: sign_ext_i, offset: offset};
  assign head    = meta_t'(fifo_rdata);

  lsu_meta_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (META_W)
  ) u_meta_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (grant),
    .pop_i   (pop),
    .wdata_i (meta_in),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign rvalid_o = pop & ~head.we;
  assign shifted  = data_rdata_i >> {head.offset, 3'b000};

  // Load formatting: right-align the addressed lanes, then zero- or sign-extend.
  always_comb begin
    rdata_o = shifted;
    case (head.typ)
      LSU_BYTE: rdata_o = {{(DATA_WIDTH-8){head.sign_ext & shifted[7]}}, shifted[7:0]};
      LSU_HALF: rdata_o = {{(DATA_WIDTH-16){head.sign_ext & shifted[15]}}, shifted[15:0]};
      default:  rdata_o = shifted;
    endcase
  end

endmodule
